// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble, one bit per clock).
// Inputs above 10^DIGITS-1 saturate to all-nines. The output register holds the
// previous result until the final DONE edge, so downstream never sees partial values.
// Optional macro OVF_FLAG_EN adds o_ovf, a registered flag for saturated inputs.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef OVF_FLAG_EN
  output logic                  o_ovf,
`endif
  output logic [4*DIGITS-1:0]   o_bcd_out
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [BIN_W-1:0]   r_shreg, w_shreg_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt, w_acc_adj;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0]   r_bcd, w_bcd_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
`ifdef OVF_FLAG_EN
  logic               r_ovf_cap, w_ovf_cap_nxt;
  logic               r_ovf, w_ovf_nxt;
`endif

  // Add-3 correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    w_acc_adj = r_acc;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef OVF_FLAG_EN
    w_ovf_cap_nxt = r_ovf_cap;
    w_ovf_nxt     = r_ovf;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_shreg_nxt = (i_bin > MAX_VAL) ? MAX_VAL : i_bin;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
`ifdef OVF_FLAG_EN
          w_ovf_cap_nxt = (i_bin > MAX_VAL);
`endif
        end
      end
      S_SHIFT: begin
        w_acc_nxt   = {w_acc_adj[ACC_W-2:0], r_shreg[BIN_W-1]};
        w_shreg_nxt = {r_shreg[BIN_W-2:0], 1'b0};
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_bcd_nxt   = r_acc;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
`ifdef OVF_FLAG_EN
        w_ovf_nxt   = r_ovf_cap;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef OVF_FLAG_EN
      r_ovf_cap <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef OVF_FLAG_EN
      r_ovf_cap <= w_ovf_cap_nxt;
      r_ovf     <= w_ovf_nxt;
`endif
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_bcd_out = r_bcd;
`ifdef OVF_FLAG_EN
  assign o_ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values against an
// arithmetic reference, and hand-written multi-cycle corner sequences.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [13:0] i_bin;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_bcd_out;
`ifdef OVF_FLAG_EN
  logic        o_ovf;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_bin     (i_bin),
    .o_busy    (o_busy),
    .o_done    (o_done),
`ifdef OVF_FLAG_EN
    .o_ovf     (o_ovf),
`endif
    .o_bcd_out (o_bcd_out)
  );

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: clamp to 9999, then peel decimal digits arithmetically.
  function automatic logic [15:0] ref_bcd(input int b);
    int v;
    logic [15:0] r;
    v = (b > 9999) ? 9999 : b;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One conversion; watches 20 negedges after the accepting edge.
  task automatic run_conv(input logic [13:0] b, output logic [15:0] res, output int lat,
                          output int bcnt, output int dcnt, output logic ovf_o);
    res = 'x; lat = -1; bcnt = 0; dcnt = 0; ovf_o = 1'b0;
    @(negedge clk);
    i_bin = b;
    i_start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        i_start = 1'b0;
        i_bin = 14'($urandom_range(0, 16383));
      end
      if (o_busy) bcnt++;
      if (o_done) begin
        dcnt++;
        if (lat < 0) begin
          lat = n - 1;
          res = o_bcd_out;
`ifdef OVF_FLAG_EN
          ovf_o = o_ovf;
`endif
        end
      end
    end
  endtask

  logic [15:0] res, prev;
  logic        ovf;
  int lat, bcnt, dcnt, viol, dn;
  int dtime[3];
  logic [15:0] dval[3];

  initial begin
    vecs[0] = '{14'd4611,  16'h4611, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd12000, 16'h9999, 1'b1};
    vecs[4] = '{14'd8840,  16'h8840, 1'b0};
    vecs[5] = '{14'd10000, 16'h9999, 1'b1};
    vecs[6] = '{14'd16383, 16'h9999, 1'b1};
    vecs[7] = '{14'd1,     16'h0001, 1'b0};
    vecs[8] = '{14'd9998,  16'h9998, 1'b0};
    vecs[9] = '{14'd5050,  16'h5050, 1'b0};

    // Reset held with start asserted.
    rst_n = 1'b0; i_start = 1'b1; i_bin = 14'd1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_bcd", 32'(o_bcd_out), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_done", 32'(o_done), 32'h0);
    end
    i_start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", {15'd0, o_busy, o_done, o_bcd_out[14:0]} | 32'(o_bcd_out[15]), 32'h0);
    end

    // Table-driven vectors with timing checks.
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, res, lat, bcnt, dcnt, ovf);
      check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd15);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd15);
      check($sformatf("vec%0d_done_pulses", i), 32'(dcnt), 32'd1);
`ifdef OVF_FLAG_EN
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
    end

    // Random values against the arithmetic reference.
    for (int i = 0; i < 20; i++) begin
      logic [13:0] b;
      b = 14'($urandom_range(0, 16383));
      run_conv(b, res, lat, bcnt, dcnt, ovf);
      check($sformatf("rand%0d_bcd(bin=%0d)", i, b), 32'(res), 32'(ref_bcd(int'(b))));
`ifdef OVF_FLAG_EN
      check($sformatf("rand%0d_ovf", i), 32'(ovf), 32'(b > 14'd9999));
`endif
    end

    // Start while busy is ignored.
    @(negedge clk);
    i_bin = 14'd4716; i_start = 1'b1;
    @(posedge clk);
    dcnt = 0; res = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) i_start = 1'b0;
      if (n == 5) begin i_start = 1'b1; i_bin = 14'd3487; end
      if (n == 6) i_start = 1'b0;
      if (o_done) begin dcnt++; res = o_bcd_out; end
    end
    check("ignored_start_bcd", 32'(res), 32'h4716);
    check("ignored_start_done_pulses", 32'(dcnt), 32'd1);

    // Reset in the middle of a conversion.
    run_conv(14'd2457, res, lat, bcnt, dcnt, ovf);
    check("pre_reset_bcd", 32'(res), 32'h2457);
    @(negedge clk);
    i_bin = 14'd8262; i_start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 1) i_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_bcd", 32'(o_bcd_out), 32'h0);
    check("midrst_busy", 32'(o_busy), 32'h0);
    check("midrst_done", 32'(o_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0; viol = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_done) dcnt++;
      if (o_bcd_out !== 16'h0 || o_busy) viol++;
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    check("midrst_stays_idle", 32'(viol), 32'd0);
    run_conv(14'd5218, res, lat, bcnt, dcnt, ovf);
    check("after_midrst_bcd", 32'(res), 32'h5218);

    // Start held high: back-to-back conversions, output never glitches.
    @(negedge clk);
    i_bin = 14'd6394; i_start = 1'b1;
    prev = o_bcd_out; viol = 0; dn = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (o_bcd_out !== prev && !o_done) viol++;
      prev = o_bcd_out;
      if (o_done && dn < 3) begin
        dtime[dn] = n;
        dval[dn] = o_bcd_out;
        dn++;
        i_bin = 14'd7499;
      end
    end
    i_start = 1'b0;
    check("cont_done_count", 32'(dn), 32'd3);
    if (dn >= 2) begin
      check("cont_first_bcd", 32'(dval[0]), 32'h6394);
      check("cont_second_bcd", 32'(dval[1]), 32'h7499);
      check("cont_period", 32'(dtime[1] - dtime[0]), 32'd16);
    end
    check("cont_no_glitch", 32'(viol), 32'd0);
    for (int n = 0; n < 20; n++) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
